// File: rtl/if_stage_s.sv
// ---------------------------------------------------------------------------
// if_stage_s -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the program counter, issues word-aligned fetch requests to instruction
// memory over a valid/ready handshake and loads the IF/ID pipeline register.
// A load-use stall holds the stage; an EX-stage redirect (flush) loads a new
// PC and forces a bubble. If a redirect arrives while a request is still
// outstanding, the DRAIN state keeps the old address on the bus until the
// stale response returns and then discards it.
//
// Parameters:
//   RESET_PC      PC value after reset
//   NOP_INSTR     bubble encoding written into IF/ID
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   stall         hold request from the hazard detection unit
//   flush         taken branch/jump resolved in EX
//   branch_target redirect PC, valid with flush (bits [1:0] ignored)
//   imem_req      fetch request valid
//   imem_addr     fetch byte address (word aligned)
//   imem_ready    memory response valid this cycle
//   imem_instr    instruction data, valid with imem_ready
//   ifid_pc       IF/ID register: PC of the instruction
//   ifid_instr    IF/ID register: instruction word
//   ifid_valid    IF/ID register holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module if_stage_s #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        req_en_q, req_en_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] target;
  logic        xfer;

  // Redirect targets are forced word aligned.
  assign target = branch_target & ~32'h0000_0003;
  // A transaction only completes while a request is actually being driven.
  assign xfer   = req_en_q & imem_ready;

  assign imem_req   = req_en_q;
  assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    req_en_d     = 1'b1;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      RUN: begin
        if (flush) begin
          pc_d         = target;
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          // The old request is still on the bus: park its address so it
          // stays stable until the stale response is absorbed.
          if (req_en_q && !imem_ready) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (stall) begin
          // PC and IF/ID hold; a response completing now is dropped and the
          // same address is simply requested again next cycle.
        end else if (xfer) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_instr;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
        end else begin
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (xfer) begin
          state_d = RUN;
        end
        // A further redirect only moves the PC; the parked address belongs
        // to the request still in flight.
        if (flush) begin
          pc_d = target;
        end
        if (flush || !stall) begin
          ifid_pc_d    = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      req_en_q     <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      req_en_q     <= req_en_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage_s.sv
// ---------------------------------------------------------------------------
// tb_if_stage_s -- directed self-checking bench for if_stage_s.
//
// Instruction memory is modelled as a combinational word = addr ^ A5A5_0000
// with a bench-controlled ready. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_if_stage_s;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  int checks;
  int errors;

  if_stage_s dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_instr    (imem_instr),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
  );

  assign imem_instr = imem_addr ^ SALT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
    branch_target = 32'h0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 00000000", ifid_pc); end
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL reset_ifid_instr got %h exp %h", ifid_instr, NOP); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid got %0b exp 0", ifid_valid); end
  endtask

  task automatic test_fetch();
    rst = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_first_req got %0b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_first_addr got %h exp 00000000", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fetch_first_valid got %0b exp 0", ifid_valid); end
    step();
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL fetch_pc0 got %h exp 00000000", ifid_pc); end
    checks++; if (ifid_instr !== (32'h0 ^ SALT)) begin errors++; $display("FAIL fetch_instr0 got %h exp a5a50000", ifid_instr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid0 got %0b exp 1", ifid_valid); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL fetch_addr4 got %h exp 00000004", imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL fetch_pc4 got %h exp 00000004", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA5A5_0004) begin errors++; $display("FAIL fetch_instr4 got %h exp a5a50004", ifid_instr); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fetch_addr8 got %h exp 00000008", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_ifid_pc[%0d] got %h exp 00000004", i, ifid_pc); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 00000008", i, imem_addr); end
    end
    stall = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h8) begin errors++; $display("FAIL stall_release_pc got %h exp 00000008", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA5A5_0008) begin errors++; $display("FAIL stall_release_instr got %h exp a5a50008", ifid_instr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got %0b exp 1", ifid_valid); end
    step();
    checks++; if (ifid_pc !== 32'hC) begin errors++; $display("FAIL stall_next_pc got %h exp 0000000c", ifid_pc); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_next_addr got %h exp 00000010", imem_addr); end
  endtask

  task automatic test_flush_ready();
    flush = 1'b1; branch_target = 32'h100;
    step();
    flush = 1'b0;
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL flush_bubble_instr got %h exp %h", ifid_instr, NOP); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble_valid got %0b exp 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL flush_bubble_pc got %h exp 00000000", ifid_pc); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL flush_addr got %h exp 00000100", imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h100) begin errors++; $display("FAIL flush_target_pc got %h exp 00000100", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA5A5_0100) begin errors++; $display("FAIL flush_target_instr got %h exp a5a50100", ifid_instr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL flush_target_valid got %0b exp 1", ifid_valid); end
  endtask

  task automatic test_ready_low();
    flush = 1'b1; branch_target = 32'h10;
    step();
    flush = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr[%0d] got %h exp 00000010", i, imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d] got %0b exp 0", i, ifid_valid); end
      checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL wait_instr[%0d] got %h exp %h", i, ifid_instr, NOP); end
    end
    imem_ready = 1'b1;
    step();
    checks++; if (ifid_pc !== 32'h10) begin errors++; $display("FAIL wait_done_pc got %h exp 00000010", ifid_pc); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL wait_done_valid got %0b exp 1", ifid_valid); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL wait_done_addr got %h exp 00000014", imem_addr); end
  endtask

  task automatic test_drain();
    // Bring the PC back to 0x10, then redirect with the request outstanding.
    flush = 1'b1; branch_target = 32'h10;
    step();
    imem_ready = 1'b0; branch_target = 32'h203;
    step();
    flush = 1'b0;
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drain_addr0 got %h exp 00000010", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drain_valid0 got %0b exp 0", ifid_valid); end
    step();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drain_addr1 got %h exp 00000010", imem_addr); end
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drain_exit_addr got %h exp 00000200", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drain_discard_valid got %0b exp 0", ifid_valid); end
    step();
    checks++; if (ifid_pc !== 32'h200) begin errors++; $display("FAIL drain_resume_pc got %h exp 00000200", ifid_pc); end
    checks++; if (ifid_instr !== 32'hA5A5_0200) begin errors++; $display("FAIL drain_resume_instr got %h exp a5a50200", ifid_instr); end
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL drain_resume_addr got %h exp 00000204", imem_addr); end
    // Second redirect while draining replaces the target.
    imem_ready = 1'b0; flush = 1'b1; branch_target = 32'h400;
    step();
    branch_target = 32'h300;
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL drain2_addr0 got %h exp 00000204", imem_addr); end
    step();
    flush = 1'b0; imem_ready = 1'b1;
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL drain2_addr1 got %h exp 00000204", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drain2_valid got %0b exp 0", ifid_valid); end
    step();
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL drain2_exit_addr got %h exp 00000300", imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h300) begin errors++; $display("FAIL drain2_resume_pc got %h exp 00000300", ifid_pc); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL drain2_resume_valid got %0b exp 1", ifid_valid); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifid_pc got %h exp fffffffc", ifid_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_flush_stall_reset();
    flush = 1'b1; stall = 1'b1; branch_target = 32'h500;
    step();
    flush = 1'b0; stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fs_valid got %0b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL fs_instr got %h exp %h", ifid_instr, NOP); end
    checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL fs_addr got %h exp 00000500", imem_addr); end
    // Enter DRAIN, then reset with the stale response arriving.
    imem_ready = 1'b0; flush = 1'b1; branch_target = 32'h600;
    step();
    flush = 1'b0;
    checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL fs_drain_addr got %h exp 00000500", imem_addr); end
    rst = 1'b1; imem_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_drain_req got %0b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_drain_addr got %h exp 00000000", imem_addr); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL rst_drain_ifid_pc got %h exp 00000000", ifid_pc); end
    checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL rst_drain_instr got %h exp %h", ifid_instr, NOP); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid got %0b exp 0", ifid_valid); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_restart_req got %0b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart_addr got %h exp 00000000", imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rst_restart_fetch got pc %h valid %0b exp pc 00000000 valid 1", ifid_pc, ifid_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush_ready();
    test_ready_low();
    test_drain();
    test_wrap();
    test_flush_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_s.md
# if_stage_s

Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues requests to instruction memory over a ready handshake, and drives the IF/ID pipeline register. The hazard detection unit's `stall` output holds this stage; the EX-stage branch/jump resolution drives `flush` with a redirect target. A DRAIN state discards memory responses that are still in flight when a redirect arrives.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: load-use stall from the hazard detection unit.
- `flush`  in  1: taken branch/jump resolved in EX.
- `branch_target`  in  32: redirect PC; valid when `flush`=1.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch byte address, word-aligned.
- `imem_ready`  in  1: memory response valid this cycle. A transaction completes when `imem_req`=1 and `imem_ready`=1.
- `imem_instr`  in  32: instruction data; valid when `imem_ready`=1.
- `ifid_pc`  out  32: IF/ID register, PC of the instruction.
- `ifid_instr`  out  32: IF/ID register, instruction word.
- `ifid_valid`  out  1: IF/ID register holds a real instruction (0 = bubble).

## Operation
- State registers: `pc` (32), `drain_addr` (32), `req_en` (1), FSM {RUN, DRAIN}.
- Outputs:
  - `imem_req` = `req_en`.
  - `imem_addr` = `drain_addr` in DRAIN, otherwise `pc`.
- Per-cycle priority: `rst` > `flush` > `stall` > `imem_ready`.
- RUN:
  - `flush`:
    - `pc` <= `branch_target`.
    - IF/ID <= bubble (`NOP_INSTR`, `valid`=0, `pc`=0).
    - If `imem_ready`=0 (request outstanding): `drain_addr` <= `pc`, next state DRAIN.
    - Else: any returned data is dropped and the FSM stays in RUN.
  - `stall` (no flush): `pc` and IF/ID hold. A completed transaction is discarded, and the same address is re-requested next cycle.
  - `imem_ready`=1: IF/ID <= {`pc`, `imem_instr`, 1}, `pc` <= `pc`+4 (mod 2^32, wraps).
  - `imem_ready`=0: `pc` holds; IF/ID <= bubble.
- DRAIN:
  - `imem_addr` stays at `drain_addr`. Returned data is never written to IF/ID.
  - `imem_ready`=1: next state RUN. The next request uses `pc`, which holds the redirect target.
  - `flush` in DRAIN: `pc` <= new `branch_target`; `drain_addr` is unchanged; the FSM stays in DRAIN unless `imem_ready`=1.
  - IF/ID holds if `stall`=1, otherwise it is loaded with a bubble (`flush` still forces a bubble).
- Address rule: while `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change.
- `branch_target[1:0]` is ignored and treated as 2'b00.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `drain_addr`=0, `req_en`=0, state RUN.
  - `ifid_pc`=0, `ifid_instr`=`NOP_INSTR`, `ifid_valid`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
- `req_en` goes to 1 on the first edge with `rst`=0, so the first request is one cycle after reset deasserts.
- Latency: a transaction completing in cycle N appears on `ifid_*` in cycle N+1. Steady-state throughput is 1 instruction/cycle with `imem_ready` held high.
- A redirect is visible on `imem_addr` in the cycle after `flush`, or in the cycle after DRAIN exits.
- Reset mid-DRAIN: returns to reset values immediately and drops the outstanding response. Memory must tolerate an abandoned request.

## Test plan
- Reset, `imem_ready`=1, memory word = addr ^ 32'hA5A5_0000 → `ifid_pc` = 0, 4, 8, 12 on consecutive cycles, with matching `ifid_instr` and `ifid_valid`=1 from the second cycle after reset.
- `stall`=1 for 2 cycles while `pc`=8 → `ifid_pc` holds at 4 and `imem_addr` holds at 8 for both cycles; 8 enters IF/ID on the cycle after `stall` drops. No instruction is skipped or duplicated.
- `flush`=1 with `branch_target`=0x100 and `imem_ready`=1 at `pc`=0x10 → next cycle IF/ID is a bubble (`NOP_INSTR`, `valid`=0) and `imem_addr`=0x100; the cycle after, `ifid_pc`=0x100.
- `imem_ready`=0 for 3 cycles at `pc`=0x10 → `imem_addr` stays 0x10, three bubbles are written into IF/ID, then `ifid_pc`=0x10.
- `flush` to 0x200 at `pc`=0x10 with `imem_ready`=0, response after 2 more cycles → `imem_addr` stays 0x10 in DRAIN, the response is discarded (never valid in IF/ID), next `imem_addr`=0x200; a second `flush` to 0x300 during DRAIN → fetch resumes at 0x300.
- `flush` and `stall` asserted together → flush wins: bubble in IF/ID, `pc` = target. Then assert `rst` during DRAIN → all outputs at reset values on the next cycle, and `imem_addr`=`RESET_PC`.
